// File: rtl/crash_course_cpu_pkg.sv
// crash_course_cpu_pkg: shared opcodes, sequencer states and instruction field positions
package crash_course_cpu_pkg;
  localparam int INSTR_W     = 16;
  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 12;
  localparam int OPERAND_MSB = 11;
  localparam int OPERAND_LSB = 0;
  localparam int COND_MSB    = 10;
  localparam int COND_LSB    = 8;
  localparam int DEST_MSB    = 7;
  localparam int DEST_LSB    = 0;
  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_JMP    = 4'h1,
    OP_BRANCH = 4'h2,
    OP_CALL   = 4'h3,
    OP_RET    = 4'h4,
    OP_HALT   = 4'hf
  } opcode_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXECUTE,
    S_HALT
  } state_e;
endpackage

// File: rtl/crash_course_cpu_instruction_decoder.sv
// crash_course_cpu_instruction_decoder: maps the instruction register to PC control and datapath outputs
module crash_course_cpu_instruction_decoder
  import crash_course_cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               active,
  input  logic               first,
  output logic               system_start,
  output logic               system_enabled,
  output logic               jump_enable,
  output logic               call_enable,
  output logic               return_enable,
  output logic               branch_enable,
  output logic [2:0]         branch_condition,
  output logic [7:0]         branch_destination,
  output logic [3:0]         exec_opcode,
  output logic [11:0]        exec_operand
);
  logic [3:0] op;
  logic       xfer;
  logic       halt;
  always_comb begin
    op                 = instr[OPCODE_MSB:OPCODE_LSB];
    halt               = op == OP_HALT;
    // the first instruction after start only advances the PC sequentially
    xfer               = active && !first;
    jump_enable        = xfer && (op == OP_JMP || op == OP_CALL || op == OP_RET);
    call_enable        = xfer && op == OP_CALL;
    return_enable      = xfer && op == OP_RET;
    branch_enable      = xfer && op == OP_BRANCH;
    branch_condition   = branch_enable ? instr[COND_MSB:COND_LSB] : 3'd0;
    branch_destination = (branch_enable || (jump_enable && !return_enable)) ? instr[DEST_MSB:DEST_LSB] : 8'd0;
    system_start       = active && first && !halt;
    system_enabled     = active && !first && !halt;
    exec_opcode        = active ? op : 4'd0;
    exec_operand       = active ? instr[OPERAND_MSB:OPERAND_LSB] : 12'd0;
  end
endmodule

// File: rtl/crash_course_cpu_instruction_sequencer.sv
// crash_course_cpu_instruction_sequencer: fetch/wait/execute control stage feeding the program counter
module crash_course_cpu_instruction_sequencer
  import crash_course_cpu_pkg::*;
#(
  parameter int ROM_LATENCY       = 1,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic                         clk_en,
  input  logic                         start_request,
  input  logic                         resume_request,
  input  logic [7:0]                   program_counter,
  output logic                         rom_read_enable,
  output logic [7:0]                   rom_address,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
  output logic                         system_start,
  output logic                         system_enabled,
  output logic                         jump_enable,
  output logic                         call_enable,
  output logic                         return_enable,
  output logic                         branch_enable,
  output logic [2:0]                   branch_condition,
  output logic [7:0]                   branch_destination,
  output logic                         exec_valid,
  output logic [3:0]                   exec_opcode,
  output logic [11:0]                  exec_operand,
  output logic                         halted
);
  if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
    $error("ROM_LATENCY %0d outside 1..3", ROM_LATENCY);
  end
  if (INSTRUCTION_WIDTH != INSTR_W) begin : g_bad_width
    $error("INSTRUCTION_WIDTH must be %0d", INSTR_W);
  end
  localparam logic [1:0] LAT_LOAD = 2'(ROM_LATENCY - 1);
  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               ir_halt;
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    ir_halt = ir_q[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
    if (clk_en) begin
      case (state_q)
        S_IDLE: if (start_request) begin
          state_d = S_FETCH;
          first_d = 1'b1;
        end
        S_FETCH: begin
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
        S_WAIT: if (cnt_q == 2'd0) begin
          ir_d    = rom_data;
          state_d = S_EXECUTE;
        end else cnt_d = cnt_q - 2'd1;
        // a HALT keeps the first flag so a resumed program still starts sequentially
        S_EXECUTE: begin
          state_d = ir_halt ? S_HALT : S_FETCH;
          first_d = ir_halt ? first_q : 1'b0;
        end
        S_HALT: if (resume_request) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end
  assign rom_read_enable = state_q == S_FETCH;
  assign rom_address     = rom_read_enable ? program_counter : 8'd0;
  assign exec_valid      = state_q == S_EXECUTE;
  assign halted          = state_q == S_HALT;
  crash_course_cpu_instruction_decoder u_decoder (
    .instr              (ir_q),
    .active             (exec_valid),
    .first              (first_q),
    .system_start       (system_start),
    .system_enabled     (system_enabled),
    .jump_enable        (jump_enable),
    .call_enable        (call_enable),
    .return_enable      (return_enable),
    .branch_enable      (branch_enable),
    .branch_condition   (branch_condition),
    .branch_destination (branch_destination),
    .exec_opcode        (exec_opcode),
    .exec_operand       (exec_operand)
  );
endmodule

// File: tb/tb_crash_course_cpu_instruction_sequencer.sv
// tb_crash_course_cpu_instruction_sequencer: scoreboard bench over ROM latencies 1 and 3 with a program-level reference walk
module tb_crash_course_cpu_instruction_sequencer;
  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [11:0] arg;
    logic        st, en, jmp, call, ret, br;
    logic [2:0]  cond;
    logic [7:0]  dest;
  } exp_t;
  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int lat, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (rom latency %0d): got %0h, want %0h", name, lat, act, req);
    end
  endtask

  // environment flag set consulted by branches: taken = flag[sel] ^ invert
  function automatic logic taken(input logic [2:0] c);
    logic [3:0] flags;
    flags = 4'b1010;
    return flags[c[1:0]] ^ c[2];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g ? 3 : 1;
    logic        sync_rst, start_request, resume_request;
    logic        clk_en = 1'b1;
    logic        fin = 1'b0;
    int          mode;
    logic [7:0]  pc;
    logic        rom_read_enable;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic        system_start, system_enabled, jump_enable, call_enable, return_enable, branch_enable;
    logic [2:0]  branch_condition;
    logic [7:0]  branch_destination;
    logic        exec_valid, halted;
    logic [3:0]  exec_opcode;
    logic [11:0] exec_operand;
    logic [15:0] mem [256];
    logic [15:0] pipe [LAT];
    logic [7:0]  env_stk [$];
    exp_t        exp_q [$];
    logic [43:0] outs, prev_outs;
    logic [32:0] act;
    logic        prev_rst = 1'b0;
    logic        prev_ce = 1'b1;
    logic        have_prev = 1'b0;
    int          en_cnt = 0;
    exp_t        e;

    crash_course_cpu_instruction_sequencer #(.ROM_LATENCY(LAT)) u_dut (
      .clk                (clk),
      .sync_rst           (sync_rst),
      .clk_en             (clk_en),
      .start_request      (start_request),
      .resume_request     (resume_request),
      .program_counter    (pc),
      .rom_read_enable    (rom_read_enable),
      .rom_address        (rom_address),
      .rom_data           (rom_data),
      .system_start       (system_start),
      .system_enabled     (system_enabled),
      .jump_enable        (jump_enable),
      .call_enable        (call_enable),
      .return_enable      (return_enable),
      .branch_enable      (branch_enable),
      .branch_condition   (branch_condition),
      .branch_destination (branch_destination),
      .exec_valid         (exec_valid),
      .exec_opcode        (exec_opcode),
      .exec_operand       (exec_operand),
      .halted             (halted)
    );

    assign act  = {exec_opcode, exec_operand, system_start, system_enabled, jump_enable, call_enable,
                   return_enable, branch_enable, branch_condition, branch_destination};
    assign outs = {rom_read_enable, rom_address, exec_valid, halted, act};

    always @(posedge clk) begin
      #1;
      clk_en = mode == 0 ? 1'b1 : mode == 1 ? ~clk_en : ($urandom_range(0, 3) != 0);
    end

    // synchronous ROM: data for an accepted read appears LAT enabled cycles later
    always @(posedge clk)
      if (!sync_rst) for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      else if (clk_en) begin
        if (rom_read_enable) pipe[0] <= mem[rom_address];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    assign rom_data = pipe[LAT-1];

    always @(posedge clk)
      if (!sync_rst) begin
        pc <= 8'd0;
        env_stk.delete();
      end else if (clk_en && (system_start || system_enabled)) begin
        if (return_enable) pc <= env_stk.size() != 0 ? env_stk.pop_back() : 8'd0;
        else if (call_enable) begin
          env_stk.push_back(pc + 8'd1);
          pc <= branch_destination;
        end else if (jump_enable || (branch_enable && taken(branch_condition))) pc <= branch_destination;
        else pc <= pc + 8'd1;
      end

    task automatic build(input int n);
      logic [7:0]  p;
      logic [7:0]  stk [$];
      logic        first;
      logic [15:0] w;
      logic [3:0]  op;
      exp_t        r;
      p = 8'd0;
      first = 1'b1;
      for (int k = 0; k < n; k++) begin
        w      = mem[p];
        op     = w[15:12];
        r.pc   = p;
        r.op   = op;
        r.arg  = w[11:0];
        r.st   = first && op != 4'hf;
        r.en   = !first && op != 4'hf;
        r.jmp  = !first && (op == 4'h1 || op == 4'h3 || op == 4'h4);
        r.call = !first && op == 4'h3;
        r.ret  = !first && op == 4'h4;
        r.br   = !first && op == 4'h2;
        r.cond = r.br ? w[10:8] : 3'd0;
        r.dest = (r.br || r.call || (!first && op == 4'h1)) ? w[7:0] : 8'd0;
        exp_q.push_back(r);
        if (op == 4'hf) break;
        if (r.ret) begin
          if (stk.size() != 0) p = stk.pop_back();
          else p = 8'd0;
        end else if (r.call) begin
          stk.push_back(p + 8'd1);
          p = w[7:0];
        end else if (r.jmp || (r.br && taken(w[10:8]))) p = w[7:0];
        else p = p + 8'd1;
        first = 1'b0;
      end
    endtask

    always @(negedge clk) begin
      if (prev_rst && !prev_ce) chk("frozen_on_clk_en_low", LAT, 64'(outs), 64'(prev_outs));
      if (!sync_rst) begin
        have_prev = 1'b0;
        en_cnt = 0;
      end else if (clk_en) begin
        en_cnt++;
        if (rom_read_enable) begin
          chk("fetch_expected", LAT, 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) chk("fetch_address", LAT, 64'(rom_address), 64'(exp_q[0].pc));
        end
        if (exec_valid) begin
          chk("exec_expected", LAT, 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("exec_decode", LAT, 64'(act),
                64'({e.op, e.arg, e.st, e.en, e.jmp, e.call, e.ret, e.br, e.cond, e.dest}));
          end
          if (have_prev) chk("instruction_period", LAT, 64'(en_cnt), 64'(LAT + 2));
          have_prev = exec_opcode != 4'hf;
          en_cnt = 0;
        end else chk("controls_idle", LAT, 64'(act), 64'd0);
        if (halted) have_prev = 1'b0;
      end
      prev_rst  = sync_rst;
      prev_ce   = clk_en;
      prev_outs = outs;
    end

    initial begin : stim
      exp_t halt_e;
      int   t;
      sync_rst = 1'b0;
      start_request = 1'b0;
      resume_request = 1'b0;
      mode = g;
      for (int i = 0; i < 256; i++) mem[8'(i)] = '0;
      mem[8'h01] = 16'h1042;
      mem[8'h42] = 16'h3010;
      mem[8'h10] = 16'h2605;
      mem[8'h05] = 16'h4000;
      for (int i = 8'h43; i < 8'h4b; i++) mem[8'(i)] = {4'($urandom_range(5, 14)), 12'($urandom)};
      mem[8'h4b] = 16'hf000;
      @(posedge clk);
      repeat (3) begin
        @(negedge clk);
        chk("in_reset_outputs", LAT, 64'(outs), 64'd0);
      end
      @(posedge clk);
      #1 sync_rst = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("idle_after_reset", LAT, 64'(outs), 64'd0);
      end
      build(64);
      halt_e = exp_q[exp_q.size() - 1];
      @(posedge clk);
      #1 start_request = 1'b1;
      t = 0;
      while (!halted && t < 1000) begin
        @(posedge clk);
        #1 t++;
      end
      chk("halt_reached", LAT, 64'(halted), 64'd1);
      repeat (10) begin
        @(negedge clk);
        chk("halt_hold", LAT, 64'({halted, rom_read_enable, system_start, system_enabled}), 64'h8);
      end
      chk("program_a_consumed", LAT, 64'(exp_q.size()), 64'd0);
      exp_q.push_back(halt_e);
      @(posedge clk);
      #1 resume_request = 1'b1;
      t = 0;
      while (halted && t < 20) begin
        @(posedge clk);
        #1 t++;
      end
      resume_request = 1'b0;
      chk("resume_leaves_halt", LAT, 64'(halted), 64'd0);
      t = 0;
      while (!halted && t < 100) begin
        @(posedge clk);
        #1 t++;
      end
      chk("halt_refetched", LAT, 64'(halted), 64'd1);
      chk("refetch_consumed", LAT, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1 sync_rst = 1'b0;
      start_request = 1'b0;
      mode = 2;
      exp_q.delete();
      for (int i = 0; i < 256; i++) mem[8'(i)] = {4'($urandom_range(0, 14)), 12'($urandom)};
      mem[8'h00] = 16'h1080;
      @(posedge clk);
      @(posedge clk);
      #1 sync_rst = 1'b1;
      build(400);
      start_request = 1'b1;
      t = 0;
      while (exp_q.size() > 375 && t < 5000) begin
        @(posedge clk);
        #1 t++;
      end
      chk("program_b_progress", LAT, 64'(exp_q.size() <= 375), 64'd1);
      start_request = 1'b0;
      t = 0;
      @(negedge clk);
      while (!(rom_read_enable && clk_en) && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("fetch_before_reset", LAT, 64'(rom_read_enable && clk_en), 64'd1);
      @(posedge clk);
      #1 sync_rst = 1'b0;
      @(posedge clk);
      #1 exp_q.delete();
      sync_rst = 1'b1;
      repeat (6) begin
        @(negedge clk);
        chk("idle_after_mid_reset", LAT, 64'(outs), 64'd0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    chk("bench_completed", 0, 64'(g_inst[0].fin && g_inst[1].fin), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
